// File: rtl/div_mon_pkg.sv
// Shared definitions for the divided-clock monitor: default sizing,
// monitor state encoding and a saturating error-count helper.
package div_mon_pkg;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_LOCK_CNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_ACQUIRE   = 2'd2,
    ST_LOCKED    = 2'd3
  } mon_state_e;

  // Increment an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module bit_sync2 (
  input  logic Clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/div_clk_mon.sv
// Divided-clock monitor: measures period and high phase of clk_div_in in
// Clk cycles, checks them against the expected ratio and tracks lock.
module div_clk_mon
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             clk_div_in,
  input  logic             mon_en,
  input  logic [CNT_W-1:0] exp_period,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             cfg_err
);

  localparam int unsigned      GW      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    GOOD_1  = GW'(1);
  localparam logic [CNT_W:0]   CNT_MAX = {(CNT_W+1){1'b1}};
  localparam logic [CNT_W:0]   CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] EXP_MIN = CNT_W'(2);

  logic             s2_s;
  logic             s3_q;
  logic             rise_s;
  logic [CNT_W:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W:0]   hi_cnt_q, hi_cnt_d;
  logic             first_q;
  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [GW-1:0]    good_q, good_d;
  logic [GW-1:0]    good_inc_s;
  logic             err_s;
  logic             eval_s;
  logic             good_s;
  logic             timeout_s;
  logic [CNT_W:0]   exp_ext_s, two_n_s, half_lo_s, half_hi_s;
  logic [CNT_W-1:0] per_clamp_s, hi_clamp_s;

  logic             locked_q;
  logic             err_pulse_q;
  logic [7:0]       err_cnt_q;
  logic [CNT_W-1:0] meas_period_q, meas_high_q;
  logic             meas_valid_q;
  logic             cfg_err_q;

  bit_sync2 u_sync (
    .Clk   (Clk),
    .rst_n (rst_n),
    .d_i   (clk_div_in),
    .q_o   (s2_s)
  );

  assign rise_s     = s2_s & ~s3_q;
  assign eval_s     = rise_s & first_q;
  assign exp_ext_s  = {1'b0, exp_q};
  assign two_n_s    = {exp_q, 1'b0};
  assign half_lo_s  = {2'b00, exp_q[CNT_W-1:1]};
  assign half_hi_s  = half_lo_s + {{CNT_W{1'b0}}, exp_q[0]};
  assign good_s     = (per_cnt_q == exp_ext_s) &&
                      ((hi_cnt_q == half_lo_s) || (hi_cnt_q == half_hi_s));
  // A rise in the same cycle always wins over the timeout.
  assign timeout_s  = ~rise_s & (per_cnt_q >= two_n_s);
  assign good_inc_s = good_q + GOOD_1;
  assign per_clamp_s = per_cnt_q[CNT_W] ? {CNT_W{1'b1}} : per_cnt_q[CNT_W-1:0];
  assign hi_clamp_s  = hi_cnt_q[CNT_W]  ? {CNT_W{1'b1}} : hi_cnt_q[CNT_W-1:0];

  // Period and high-phase counters, restarted by every rise.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise_s) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
    end else begin
      if (per_cnt_q != CNT_MAX) begin
        per_cnt_d = per_cnt_q + CNT_ONE;
      end else begin
        per_cnt_d = per_cnt_q;
      end
      if (s2_s && (hi_cnt_q != CNT_MAX)) begin
        hi_cnt_d = hi_cnt_q + CNT_ONE;
      end else begin
        hi_cnt_d = hi_cnt_q;
      end
    end
  end

  // Monitor FSM: next state, good-period tracking and error detection.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    exp_d   = exp_q;
    err_s   = 1'b0;
    if (!mon_en) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exp_period >= EXP_MIN) begin
            state_d = ST_WAIT_EDGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_EDGE: begin
          if (rise_s) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
            exp_d   = exp_period;
          end else begin
            state_d = ST_WAIT_EDGE;
          end
        end
        ST_ACQUIRE: begin
          if (eval_s) begin
            if (!good_s) begin
              good_d = '0;
              err_s  = 1'b1;
            end else if (good_inc_s >= LOCK_V) begin
              good_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_inc_s;
            end
          end else if (timeout_s) begin
            err_s   = 1'b1;
            good_d  = '0;
            state_d = ST_WAIT_EDGE;
          end else begin
            state_d = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (eval_s && !good_s) begin
            err_s   = 1'b1;
            good_d  = '0;
            state_d = ST_ACQUIRE;
          end else if (timeout_s) begin
            err_s   = 1'b1;
            good_d  = '0;
            state_d = ST_WAIT_EDGE;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // State, counters, edge-detect flop and registered outputs.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_q          <= 1'b0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      first_q       <= 1'b0;
      state_q       <= ST_IDLE;
      exp_q         <= '0;
      good_q        <= '0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= 8'd0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      s3_q         <= s2_s;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      first_q      <= first_q | rise_s;
      state_q      <= state_d;
      exp_q        <= exp_d;
      good_q       <= good_d;
      locked_q     <= (state_d == ST_LOCKED);
      err_pulse_q  <= err_s;
      err_cnt_q    <= err_s ? sat_inc8(err_cnt_q) : err_cnt_q;
      meas_valid_q <= eval_s;
      cfg_err_q    <= (exp_period < EXP_MIN);
      if (eval_s) begin
        meas_period_q <= per_clamp_s;
        meas_high_q   <= hi_clamp_s;
      end else begin
        meas_period_q <= meas_period_q;
        meas_high_q   <= meas_high_q;
      end
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;
  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_div_clk_mon.sv
// Directed bench for div_clk_mon: lock acquisition, period error, timeout,
// disable, bad configuration, error saturation and asynchronous reset.
module tb_div_clk_mon;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic       clk_div_in;
  logic       mon_en;
  logic [7:0] exp_period;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [7:0] meas_period;
  logic [7:0] meas_high;
  logic       meas_valid;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mv_cnt = 0;
  int ep_cnt = 0;
  int mv_last_cyc = 0;
  int ep_last_cyc = 0;
  logic ep_prev = 1'b0;
  int base_mv;
  int base_ep;

  div_clk_mon dut (
    .Clk         (Clk),
    .rst_n       (rst_n),
    .clk_div_in  (clk_div_in),
    .mon_en      (mon_en),
    .exp_period  (exp_period),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .cfg_err     (cfg_err)
  );

  always #5 Clk = ~Clk;

  // Event monitor: counts pulse cycles and records when they occur.
  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (meas_valid) begin
      mv_cnt      <= mv_cnt + 1;
      mv_last_cyc <= cyc;
    end
    if (err_pulse) begin
      ep_cnt <= ep_cnt + 1;
      if (!ep_prev) ep_last_cyc <= cyc;
    end
    ep_prev <= err_pulse;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic run_periods(input int k, input int n, input int hi);
    for (int p = 0; p < k; p++) begin
      for (int i = 0; i < n; i++) begin
        @(posedge Clk);
        #1;
        clk_div_in = (i < hi);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"},      locked,      0);
    chk({tag, "_err_pulse"},   err_pulse,   0);
    chk({tag, "_err_cnt"},     err_cnt,     0);
    chk({tag, "_meas_period"}, meas_period, 0);
    chk({tag, "_meas_high"},   meas_high,   0);
    chk({tag, "_meas_valid"},  meas_valid,  0);
    chk({tag, "_cfg_err"},     cfg_err,     0);
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_div_in = 1'b0;
    mon_en     = 1'b0;
    exp_period = 8'd5;
    tick(3);
    chk_reset_outputs("por");

    // Divide-by-5, 50% duty: lock after 5 rises (first rise is not evaluated)
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick(5);
    chk("cfg_err_ok", cfg_err, 0);
    base_mv = mv_cnt;
    run_periods(4, 5, 3);
    chk("not_locked_3good", locked, 0);
    run_periods(1, 5, 3);
    chk("locked_4good", locked, 1);
    chk("meas_valid_count", mv_cnt - base_mv, 4);
    chk("meas_period_5", meas_period, 5);
    chk("meas_high_3", meas_high, 3);
    chk("err_cnt_0", err_cnt, 0);

    // One stretched period of 6 cycles
    base_ep = ep_cnt;
    run_periods(1, 6, 3);
    run_periods(1, 5, 3);
    chk("stretch_err_pulses", ep_cnt - base_ep, 1);
    chk("stretch_err_cnt", err_cnt, 1);
    chk("stretch_unlock", locked, 0);
    chk("stretch_meas_period", meas_period, 6);
    chk("stretch_meas_high", meas_high, 3);
    run_periods(3, 5, 3);
    chk("relock_not_yet", locked, 0);
    run_periods(1, 5, 3);
    chk("relock", locked, 1);

    // Stall the divided clock: timeout at 2*N after the last rise
    base_ep = ep_cnt;
    tick(25);
    chk("timeout_err_pulses", ep_cnt - base_ep, 1);
    chk("timeout_delay", ep_last_cyc - mv_last_cyc, 10);
    chk("timeout_err_cnt", err_cnt, 2);
    chk("timeout_unlock", locked, 0);
    run_periods(4, 5, 3);
    chk("restart_not_yet", locked, 0);
    run_periods(1, 5, 3);
    chk("restart_relock", locked, 1);
    chk("restart_err_cnt", err_cnt, 2);

    // Disable: locked drops next cycle, counters and measurements kept
    mon_en = 1'b0;
    tick(1);
    chk("disable_unlock", locked, 0);
    tick(3);
    chk("disable_err_cnt", err_cnt, 2);
    chk("disable_meas_period", meas_period, 5);
    chk("disable_meas_high", meas_high, 3);

    // Bad configuration: exp_period = 1 never leaves IDLE
    exp_period = 8'd1;
    mon_en     = 1'b1;
    base_ep    = ep_cnt;
    run_periods(10, 2, 1);
    tick(5);
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_no_lock", locked, 0);
    chk("cfg_err_cnt", err_cnt, 2);
    chk("cfg_no_pulses", ep_cnt - base_ep, 0);

    // Error flood: N=2 against period 4; rise coincides with 2*N every period
    mon_en = 1'b0;
    tick(2);
    exp_period = 8'd2;
    mon_en     = 1'b1;
    tick(3);
    chk("cfg_err_clear", cfg_err, 0);
    base_ep = ep_cnt;
    run_periods(270, 4, 2);
    tick(10);
    chk("flood_err_pulses", ep_cnt - base_ep, 270);
    chk("flood_err_cnt_sat", err_cnt, 255);
    chk("flood_no_lock", locked, 0);

    // Asynchronous reset while locked
    mon_en = 1'b0;
    tick(2);
    exp_period = 8'd5;
    mon_en     = 1'b1;
    tick(3);
    run_periods(5, 5, 3);
    chk("prereset_locked", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick(2);
    rst_n   = 1'b1;
    base_mv = mv_cnt;
    run_periods(1, 5, 3);
    chk("post_rst_no_meas", mv_cnt - base_mv, 0);
    run_periods(1, 5, 3);
    chk("post_rst_first_meas", mv_cnt - base_mv, 1);
    chk("post_rst_meas_period", meas_period, 5);
    run_periods(3, 5, 3);
    chk("post_rst_relock", locked, 1);
    chk("post_rst_err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_clk_mon.md
DIV_CLK_MON -- requirements
Module: div_clk_mon

Interface
REQ-001 Parameter CNT_W, default 8: width of the expected period and of all period measurements.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive good periods required to declare lock.
REQ-003 Clk  input  1  system clock, posedge active; the divider's source clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_div_in  input  1  divided clock under test, odd or even ratio, treated as asynchronous.
REQ-006 mon_en  input  1  monitor enable; 0 forces IDLE.
REQ-007 exp_period  input  CNT_W  expected division ratio N in Clk cycles.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 err_pulse  output  1  one-cycle pulse on each period or timeout error.
REQ-010 err_cnt  output  8  saturating error count.
REQ-011 meas_period  output  CNT_W  last measured rising-to-rising period in Clk cycles.
REQ-012 meas_high  output  CNT_W  sampled high-phase length of the last period in Clk cycles.
REQ-013 meas_valid  output  1  one-cycle pulse when meas_period and meas_high update.
REQ-014 cfg_err  output  1  high while exp_period < 2.

Function
REQ-015 clk_div_in SHALL pass through a 2-flop synchronizer; a third flop SHALL provide rising-edge detection (rise = s2 & ~s3).
REQ-016 Period counter: loads 1 on rise; otherwise increments each cycle and saturates at all-ones (CNT_W+1 bits).
REQ-017 High counter: loads 1 on rise; otherwise increments while s2 is high, and holds while s2 is low.
REQ-018 On each rise after the first, meas_period and meas_high SHALL capture the counter values from the previous cycle, and meas_valid SHALL pulse in the same cycle.
REQ-019 A period is good iff meas_period == exp_period and meas_high is in {floor(N/2), ceil(N/2)}.
REQ-020 exp_period SHALL be latched on the WAIT_EDGE to ACQUIRE transition; later changes are ignored until the monitor re-enters WAIT_EDGE.
REQ-021 States: IDLE, WAIT_EDGE, ACQUIRE, LOCKED.
REQ-022 IDLE -> WAIT_EDGE when mon_en=1 and exp_period >= 2; otherwise stay in IDLE, with cfg_err = (exp_period < 2).
REQ-023 WAIT_EDGE -> ACQUIRE on the first rise; the good-period counter clears.
REQ-024 ACQUIRE: each good period increments the good-period counter; a bad period clears it and fires an error; reaching LOCK_CNT moves to LOCKED, with locked=1 the next cycle.
REQ-025 LOCKED: a bad period fires an error and moves to ACQUIRE with the good-period counter cleared.
REQ-026 Timeout: in ACQUIRE or LOCKED, if the period counter reaches 2*N without a rise, the monitor fires an error and moves to WAIT_EDGE.
REQ-027 An error SHALL pulse err_pulse for exactly one cycle and increment err_cnt, saturating at 255.
REQ-028 mon_en=0 in any state SHALL force IDLE next cycle, drop locked, and preserve err_cnt and meas_*.
REQ-029 If rise and timeout coincide, rise SHALL take precedence (no timeout).
REQ-030 Latency from a clk_div_in edge to rise SHALL be 3 Clk cycles.

Reset
REQ-031 On rst_n low: state=IDLE, all synchronizer and counter flops 0, locked=0, err_pulse=0, err_cnt=0, meas_period=0, meas_high=0, meas_valid=0, cfg_err=0.
REQ-032 A reset mid-operation SHALL discard partial measurements; the first period after reset SHALL NOT be evaluated.

Structure
REQ-033 Package div_mon_pkg SHALL hold the state enum and the default CNT_W and LOCK_CNT constants.
REQ-034 The synchronizer SHALL be a sub-module named bit_sync2 (2-flop, async active-low reset); all other logic stays in div_clk_mon.

Verification
REQ-035 exp_period=5, mon_en=1, clk_div_in from a 50%-duty divide-by-5 -> meas_period=5 every period, meas_high in {2,3}, locked high after the 4th good period, err_cnt=0.
REQ-036 While locked, stretch one period to 6 cycles -> one err_pulse, err_cnt=1, locked drops, relock after 4 further good periods.
REQ-037 While locked, hold clk_div_in low -> timeout 10 cycles after the last rise, err_cnt increments, state WAIT_EDGE; restarting the clock relocks.
REQ-038 exp_period=1, mon_en=1 -> cfg_err=1, locked never asserts, err_cnt stays 0.
REQ-039 Assert rst_n low while locked -> all outputs at reset values within the same cycle (asynchronous), and no measurement until two rises after release.
REQ-040 Inject more than 255 errors -> err_cnt holds at 255, and err_pulse still pulses once per error.
